// File: rtl/pcs_sync_param_pkg.sv
// Shared types and constants for the parametrised PCS
// code-group synchronizer and its classifier.
package pcs_sync_param_pkg;

  localparam int CG_W   = 10;
  localparam int ACQ_W  = 3;
  localparam int GOOD_W = 4;
  localparam int LVL_W  = 3;

  // abcdeif prefix shared by K28.1/K28.5/K28.7
  localparam logic [6:0] COMMA_N = 7'b0011111;
  localparam logic [6:0] COMMA_P = 7'b1100000;

  typedef enum logic [1:0] {
    PH_LOSS,
    PH_CDET,
    PH_ACQ,
    PH_SYNC
  } phase_t;

endpackage

// File: rtl/pcs_sync_param_cg_classify.sv
// 8B/10B code-group classifier: flags table membership
// (either disparity) and K28.1/5/7 commas.
module pcs_sync_param_cg_classify
  import pcs_sync_param_pkg::*;
(
  input  logic [CG_W-1:0] cg,
  output logic            valid,
  output logic            comma
);

  logic [5:0] six;
  logic [3:0] four;
  logic       vm, vp;
  logic       rd_m, rd_p;
  logic       a7m, a7p;
  logic       dvalid, k28, kx7;

  assign six  = cg[9:4];
  assign four = cg[3:0];

  // 4b sub-block legal for running disparity rd
  function automatic logic dat4(
    input logic       rd,
    input logic [3:0] f,
    input logic       a7
  );
    logic ok;
    ok = 1'b0;
    if (!rd) begin
      case (f)
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110: ok = 1'b1;
        4'b1110: ok = !a7;
        4'b0111: ok = a7;
        default: ok = 1'b0;
      endcase
    end else begin
      case (f)
        4'b0100, 4'b1001, 4'b0101, 4'b0011,
        4'b0010, 4'b1010, 4'b0110: ok = 1'b1;
        4'b0001: ok = !a7;
        4'b1000: ok = a7;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  always_comb begin
    vm = 1'b0;
    vp = 1'b0;
    case (six)
      6'b110001, 6'b101001, 6'b011001, 6'b100101,
      6'b010101, 6'b110100, 6'b001101, 6'b101100,
      6'b011100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b100110,
      6'b010110, 6'b001110: begin
        vm = 1'b1;
        vp = 1'b1;
      end
      6'b100111, 6'b011101, 6'b101101, 6'b110101,
      6'b111000, 6'b111001, 6'b010111, 6'b011011,
      6'b111010, 6'b110011, 6'b110110, 6'b101110,
      6'b011110, 6'b101011: vm = 1'b1;
      6'b011000, 6'b100010, 6'b010010, 6'b001010,
      6'b000111, 6'b000110, 6'b101000, 6'b100100,
      6'b000101, 6'b001100, 6'b001001, 6'b010001,
      6'b100001, 6'b010100: vp = 1'b1;
      default: ;
    endcase
  end

  // running disparity after the 6b block
  assign rd_m = ($countones(six) == 4);
  assign rd_p = ($countones(six) != 2);

  assign a7m = six inside {6'b100011, 6'b010011, 6'b001011};
  assign a7p = six inside {6'b110100, 6'b101100, 6'b011100};

  assign dvalid =
    (vm && dat4(rd_m, four, rd_m ? a7p : a7m)) ||
    (vp && dat4(rd_p, four, rd_p ? a7p : a7m));

  assign k28 =
    (six == 6'b001111 && four inside {
      4'b0100, 4'b1001, 4'b0101, 4'b0011,
      4'b0010, 4'b1010, 4'b0110, 4'b1000}) ||
    (six == 6'b110000 && four inside {
      4'b1011, 4'b0110, 4'b1010, 4'b1100,
      4'b1101, 4'b0101, 4'b1001, 4'b0111});

  assign kx7 =
    (four == 4'b1000 && six inside {
      6'b111010, 6'b110110, 6'b101110, 6'b011110}) ||
    (four == 4'b0111 && six inside {
      6'b000101, 6'b001001, 6'b010001, 6'b100001});

  assign valid = dvalid || k28 || kx7;
  assign comma = valid &&
    (cg[9:3] == COMMA_N || cg[9:3] == COMMA_P);

endmodule

// File: rtl/pcs_sync_param.sv
// Parametrised PCS receive code-group synchronizer with
// hysteresis levels, sync-level output and event pulses.
module pcs_sync_param
  import pcs_sync_param_pkg::*;
#(
  parameter int unsigned COMMA_ACQ    = 3,
  parameter int unsigned LOSS_DEPTH   = 4,
  parameter int unsigned GOOD_CGS_MAX = 3
) (
  input  logic             Clk,
  input  logic             mr_main_reset_n,
  input  logic             power_on,
  input  logic [CG_W-1:0]  PUDI,
  input  logic             PUDI_indicate,
  output logic [CG_W:0]    SUDI,
  output logic             code_sync_status,
  output logic [LVL_W-1:0] sync_level,
  output logic             sync_acquired,
  output logic             sync_lost
);

  localparam logic [ACQ_W-1:0]  ACQ_N  = ACQ_W'(COMMA_ACQ);
  localparam logic [LVL_W-1:0]  DEP_N  = LVL_W'(LOSS_DEPTH);
  localparam logic [GOOD_W-1:0] GOOD_N = GOOD_W'(GOOD_CGS_MAX);

  phase_t            phase_q, phase_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [ACQ_W-1:0]  acq_q, acq_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic              even_q, even_d;
  logic              acq_p, lost_p;
  logic              valid, comma, cgbad;
  logic              rst;

  pcs_sync_param_cg_classify u_cls (
    .cg    (PUDI),
    .valid (valid),
    .comma (comma)
  );

  assign rst      = !mr_main_reset_n || !power_on;
  assign cgbad    = !valid || (comma && even_q);
  assign good_inc = good_q + GOOD_W'(1);

  always_ff @(posedge Clk) begin
    if (rst) begin
      phase_q       <= PH_LOSS;
      lvl_q         <= '0;
      acq_q         <= '0;
      good_q        <= '0;
      even_q        <= 1'b0;
      SUDI          <= '0;
      sync_acquired <= 1'b0;
      sync_lost     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      lvl_q         <= lvl_d;
      acq_q         <= acq_d;
      good_q        <= good_d;
      even_q        <= even_d;
      sync_acquired <= acq_p;
      sync_lost     <= lost_p;
      if (PUDI_indicate) begin
        SUDI <= {even_d, PUDI};
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    lvl_d   = lvl_q;
    acq_d   = acq_q;
    good_d  = good_q;
    even_d  = even_q;
    acq_p   = 1'b0;
    lost_p  = 1'b0;
    if (PUDI_indicate) begin
      even_d = !even_q;
      case (phase_q)
        PH_LOSS: begin
          if (comma) begin
            phase_d = PH_CDET;
            acq_d   = ACQ_W'(1);
            even_d  = 1'b1;
          end
        end
        PH_CDET: begin
          if (valid && !comma) begin
            if (acq_q == ACQ_N) begin
              phase_d = PH_SYNC;
              lvl_d   = LVL_W'(1);
              good_d  = '0;
              acq_p   = 1'b1;
            end else begin
              phase_d = PH_ACQ;
            end
          end else begin
            phase_d = PH_LOSS;
            acq_d   = '0;
            good_d  = '0;
          end
        end
        PH_ACQ: begin
          if (comma && !even_q) begin
            phase_d = PH_CDET;
            acq_d   = acq_q + ACQ_W'(1);
            even_d  = 1'b1;
          end else if (comma || !valid) begin
            phase_d = PH_LOSS;
            acq_d   = '0;
            good_d  = '0;
          end
        end
        PH_SYNC: begin
          if (cgbad) begin
            good_d = '0;
            if (lvl_q == DEP_N) begin
              phase_d = PH_LOSS;
              lvl_d   = '0;
              acq_d   = '0;
              lost_p  = 1'b1;
            end else begin
              lvl_d = lvl_q + LVL_W'(1);
            end
          end else if (lvl_q != LVL_W'(1)) begin
            // a run of good groups climbs back one level
            if (good_inc == GOOD_N) begin
              lvl_d  = lvl_q - LVL_W'(1);
              good_d = '0;
            end else begin
              good_d = good_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign code_sync_status = (phase_q == PH_SYNC);
  assign sync_level       = lvl_q;

endmodule

// File: tb/tb_pcs_sync_param.sv
// Bench for pcs_sync_param: default and swept instances
// against an encoder-table driven behavioural model.
module tb_pcs_sync_param;

  logic       Clk = 1'b0;
  logic       mr_main_reset_n;
  logic       power_on;
  logic       PUDI_indicate;
  logic [9:0] PUDI;

  logic [10:0] sudi0, sudi1;
  logic        st0, st1;
  logic [2:0]  lv0, lv1;
  logic        aq0, aq1, ls0, ls1;

  always #5 Clk = ~Clk;

  pcs_sync_param u_def (
    .Clk              (Clk),
    .mr_main_reset_n  (mr_main_reset_n),
    .power_on         (power_on),
    .PUDI             (PUDI),
    .PUDI_indicate    (PUDI_indicate),
    .SUDI             (sudi0),
    .code_sync_status (st0),
    .sync_level       (lv0),
    .sync_acquired    (aq0),
    .sync_lost        (ls0)
  );

  pcs_sync_param #(
    .COMMA_ACQ    (1),
    .LOSS_DEPTH   (2),
    .GOOD_CGS_MAX (1)
  ) u_swp (
    .Clk              (Clk),
    .mr_main_reset_n  (mr_main_reset_n),
    .power_on         (power_on),
    .PUDI             (PUDI),
    .PUDI_indicate    (PUDI_indicate),
    .SUDI             (sudi1),
    .code_sync_status (st1),
    .sync_level       (lv1),
    .sync_acquired    (aq1),
    .sync_lost        (ls1)
  );

  localparam logic [9:0] COMMA = 10'b1100000101;
  localparam logic [9:0] D1    = 10'b1010101010;
  localparam logic [9:0] D2    = 10'b0101010101;
  localparam logic [9:0] D3    = 10'b0110110101;
  localparam logic [9:0] MALO  = 10'b0000000000;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  int p_acq [2] = '{3, 1};
  int p_dep [2] = '{4, 2};
  int p_good[2] = '{3, 1};

  logic [5:0] t6m [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4m [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] k4m [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100,
    4'b1101, 4'b0101, 4'b1001, 4'b0111};

  bit         valid_tab [1024];
  bit         comma_tab [1024];
  logic [9:0] data_q[$];
  logic [9:0] comma_q[$];

  int        m_lvl [2];
  int        m_hunt[2];
  int        m_cnt [2];
  int        m_good[2];
  bit        m_even[2];
  bit [10:0] m_sudi[2];
  bit        m_ap  [2];
  bit        m_lp  [2];

  function automatic logic [9:0] enc(
    input int x, input int y, input bit k, input bit rd
  );
    logic [5:0] s;
    logic [3:0] f;
    bit r, a7;
    s = (k && x == 28) ? 6'b001111 : t6m[x];
    if (rd && (($countones(s) != 3) || x == 7)) s = ~s;
    r = rd ^ ($countones(s) != 3);
    if (k && x == 28) f = k4m[y];
    else if (k) f = 4'b0111;
    else begin
      a7 = (y == 7) &&
        ((!r && (x == 17 || x == 18 || x == 20)) ||
         (r && (x == 11 || x == 13 || x == 14)));
      f = a7 ? 4'b0111 : t4m[y];
    end
    if (r && (($countones(f) != 2) || (!k && y == 3) ||
        (k && x == 28))) f = ~f;
    return {s, f};
  endfunction

  task automatic build_tables();
    logic [9:0] w;
    int kx [4] = '{23, 27, 29, 30};
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 8; y++)
        for (int rd = 0; rd < 2; rd++)
          valid_tab[enc(x, y, 1'b0, rd[0])] = 1'b1;
    for (int y = 0; y < 8; y++)
      for (int rd = 0; rd < 2; rd++) begin
        w = enc(28, y, 1'b1, rd[0]);
        valid_tab[w] = 1'b1;
        if (y == 1 || y == 5 || y == 7) comma_tab[w] = 1'b1;
      end
    for (int i = 0; i < 4; i++)
      for (int rd = 0; rd < 2; rd++)
        valid_tab[enc(kx[i], 7, 1'b1, rd[0])] = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      w = 10'(i);
      if (comma_tab[i]) comma_q.push_back(w);
      else if (valid_tab[i]) data_q.push_back(w);
    end
  endtask

  task automatic chk(
    input string nm, input int k,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    bit v, c, bad, nev;
    if (!mr_main_reset_n || !power_on) begin
      m_lvl[k] = 0; m_hunt[k] = 0; m_cnt[k] = 0;
      m_good[k] = 0; m_even[k] = 0; m_sudi[k] = '0;
      m_ap[k] = 0; m_lp[k] = 0;
    end else begin
      m_ap[k] = 0;
      m_lp[k] = 0;
      if (PUDI_indicate) begin
        v   = valid_tab[PUDI];
        c   = comma_tab[PUDI];
        bad = !v || (c && m_even[k]);
        nev = !m_even[k];
        if (m_lvl[k] == 0) begin
          if (m_hunt[k] == 0) begin
            if (c) begin
              m_hunt[k] = 1; m_cnt[k] = 1; nev = 1;
            end
          end else if (m_hunt[k] == 1) begin
            if (v && !c) begin
              if (m_cnt[k] == p_acq[k]) begin
                m_lvl[k] = 1; m_hunt[k] = 0;
                m_good[k] = 0; m_ap[k] = 1;
              end else m_hunt[k] = 2;
            end else begin
              m_hunt[k] = 0; m_cnt[k] = 0;
            end
          end else begin
            if (c && !m_even[k]) begin
              m_hunt[k] = 1; m_cnt[k]++; nev = 1;
            end else if (c || !v) begin
              m_hunt[k] = 0; m_cnt[k] = 0;
            end
          end
        end else if (bad) begin
          m_good[k] = 0;
          if (m_lvl[k] == p_dep[k]) begin
            m_lvl[k] = 0; m_hunt[k] = 0;
            m_cnt[k] = 0; m_lp[k] = 1;
          end else m_lvl[k]++;
        end else if (m_lvl[k] > 1) begin
          m_good[k]++;
          if (m_good[k] == p_good[k]) begin
            m_lvl[k]--; m_good[k] = 0;
          end
        end
        m_even[k] = nev;
        m_sudi[k] = {nev, PUDI};
      end
    end
  endtask

  always @(posedge Clk) begin
    step(0);
    step(1);
  end

  task automatic cmp(
    input int k, input logic [10:0] s, input logic st,
    input logic [2:0] lv, input logic aq, input logic ls
  );
    chk("sudi",   k, 32'(s),  32'(m_sudi[k]));
    chk("status", k, 32'(st), 32'(m_lvl[k] != 0));
    chk("level",  k, 32'(lv), 32'(m_lvl[k]));
    chk("acq_p",  k, 32'(aq), 32'(m_ap[k]));
    chk("lost_p", k, 32'(ls), 32'(m_lp[k]));
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      cmp(0, sudi0, st0, lv0, aq0, ls0);
      cmp(1, sudi1, st1, lv1, aq1, ls1);
    end
  end

  task automatic cyc(input logic [9:0] cg, input logic ind);
    PUDI = cg;
    PUDI_indicate = ind;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [9:0] pick_data();
    return data_q[$urandom_range(0, data_q.size() - 1)];
  endfunction

  function automatic logic [9:0] pick_comma();
    return comma_q[$urandom_range(0, comma_q.size() - 1)];
  endfunction

  initial begin
    int r;
    logic ind;
    build_tables();
    mr_main_reset_n = 1'b0;
    power_on        = 1'b1;
    PUDI            = '0;
    PUDI_indicate   = 1'b0;
    @(posedge Clk);
    #1;
    cmp_en = 1'b1;
    chk("tab_comma", 0, 32'(comma_tab[COMMA]), 32'd1);
    chk("n_commas",  0, 32'(comma_q.size()),   32'd6);
    cyc(D1, 1'b1);
    chk("rst_sudi",   0, 32'(sudi0), 32'd0);
    chk("rst_level",  1, 32'(lv1),   32'd0);
    chk("rst_status", 0, 32'(st0),   32'd0);
    mr_main_reset_n = 1'b1;

    // acquisition: default needs 3 commas, sweep needs 1
    cyc(COMMA, 1'b1);
    chk("even_c1", 0, 32'(sudi0[10]), 32'd1);
    cyc(D1, 1'b1);
    chk("even_d1",  0, 32'(sudi0[10]), 32'd0);
    chk("swp_acq",  1, 32'(aq1),       32'd1);
    chk("swp_lvl",  1, 32'(lv1),       32'd1);
    cyc(COMMA, 1'b1);
    cyc(D2, 1'b1);
    cyc(COMMA, 1'b1);
    chk("def_nosync", 0, 32'(st0), 32'd0);
    cyc(D3, 1'b1);
    chk("def_acq",    0, 32'(aq0),   32'd1);
    chk("def_status", 0, 32'(st0),   32'd1);
    chk("def_sudi",   0, 32'(sudi0), 32'({1'b0, D3}));

    // one bad group, then recovery
    cyc(MALO, 1'b1);
    chk("lvl2", 0, 32'(lv0), 32'd2);
    chk("lvl2", 1, 32'(lv1), 32'd2);
    cyc(D1, 1'b1);
    chk("swp_back", 1, 32'(lv1), 32'd1);
    cyc(D3, 1'b1);
    chk("def_hold2", 0, 32'(lv0), 32'd2);
    cyc(D2, 1'b1);
    chk("def_back", 0, 32'(lv0), 32'd1);

    // run of bad groups to loss
    cyc(MALO, 1'b1);
    cyc(MALO, 1'b1);
    chk("swp_lost", 1, 32'(ls1), 32'd1);
    chk("def_lvl3", 0, 32'(lv0), 32'd3);
    cyc(MALO, 1'b1);
    chk("def_lvl4", 0, 32'(lv0), 32'd4);
    cyc(MALO, 1'b1);
    chk("def_lost",   0, 32'(ls0), 32'd1);
    chk("def_lvl0",   0, 32'(lv0), 32'd0);
    chk("def_st_off", 0, 32'(st0), 32'd0);

    // odd-slot comma aborts acquisition
    cyc(COMMA, 1'b1);
    cyc(D1, 1'b1);
    cyc(COMMA, 1'b1);
    cyc(D2, 1'b1);
    cyc(COMMA, 1'b1);
    cyc(COMMA, 1'b1);
    chk("odd_comma", 0, 32'(st0), 32'd0);
    chk("swp_odd",   1, 32'(lv1), 32'd2);

    // PUDI_indicate low mid-acquisition
    mr_main_reset_n = 1'b0;
    cyc(MALO, 1'b1);
    mr_main_reset_n = 1'b1;
    cyc(COMMA, 1'b1);
    cyc(D1, 1'b1);
    repeat (5) begin
      cyc(10'($urandom), 1'b0);
      chk("hold_sudi", 0, 32'(sudi0), 32'({1'b0, D1}));
    end
    cyc(COMMA, 1'b1);
    cyc(D2, 1'b1);
    cyc(COMMA, 1'b1);
    cyc(D3, 1'b1);
    chk("resume_acq", 0, 32'(aq0), 32'd1);
    chk("resume_lvl", 0, 32'(lv0), 32'd1);

    // power_on and reset while synced
    power_on = 1'b0;
    cyc(D1, 1'b1);
    chk("pwr_sudi",   0, 32'(sudi0), 32'd0);
    chk("pwr_status", 0, 32'(st0),   32'd0);
    power_on = 1'b1;
    cyc(COMMA, 1'b1);
    cyc(D1, 1'b1);
    chk("swp_resync", 1, 32'(lv1), 32'd1);
    mr_main_reset_n = 1'b0;
    cyc(D2, 1'b1);
    chk("mid_rst_lvl",  1, 32'(lv1),   32'd0);
    chk("mid_rst_sudi", 1, 32'(sudi1), 32'd0);
    chk("mid_rst_st",   1, 32'(st1),   32'd0);
    mr_main_reset_n = 1'b1;

    // randomized traffic, mostly comma/data pairs
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      mr_main_reset_n = ($urandom_range(0, 299) != 0);
      power_on        = ($urandom_range(0, 299) != 0);
      ind             = ($urandom_range(0, 19) != 0);
      if (r < 70) begin
        cyc(pick_comma(), ind);
        cyc(pick_data(), ($urandom_range(0, 19) != 0));
      end else if (r < 85) begin
        cyc(pick_data(), ind);
      end else if (r < 93) begin
        cyc(10'($urandom), ind);
      end else begin
        cyc(pick_comma(), ind);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
